kmeans_accumulator_k3_d4: RTL and testbench

KMEANS_ACCUMULATOR_K3_D4 -- requirements
Module: kmeans_accumulator_k3_d4

---
 rtl/kmeans_accumulator_k3_d4_if.sv | 40 ++++
 rtl/kmeans_accumulator_k3_d4.sv | 185 ++++++++++++++++++
 tb/tb_kmeans_accumulator_k3_d4.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kmeans_accumulator_k3_d4_if.sv
// Sample/record bus of the k-means accumulator (3 centroids, 4 dimensions).
// master = sample producer and record consumer; slave = the accumulator.
interface kmeans_accumulator_k3_d4_if #(
    parameter int input_data_width = 16,
    parameter int acc_width        = 32,
    parameter int cnt_width        = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [input_data_width-1:0] input_data0;
    logic [input_data_width-1:0] input_data1;
    logic [input_data_width-1:0] input_data2;
    logic [input_data_width-1:0] input_data3;
    logic [1:0]                  selected_centroid;
    logic                        out_valid;
    logic                        out_ready;
    logic [1:0]                  out_idx;
    logic [acc_width-1:0]        out_sum0;
    logic [acc_width-1:0]        out_sum1;
    logic [acc_width-1:0]        out_sum2;
    logic [acc_width-1:0]        out_sum3;
    logic [cnt_width-1:0]        out_count;
    logic                        out_last;
    logic                        overflow;

    modport master (
        output in_valid, in_last, input_data0, input_data1, input_data2, input_data3,
               selected_centroid, out_ready,
        input  in_ready, out_valid, out_idx, out_sum0, out_sum1, out_sum2, out_sum3,
               out_count, out_last, overflow
    );

    modport slave (
        input  in_valid, in_last, input_data0, input_data1, input_data2, input_data3,
               selected_centroid, out_ready,
        output in_ready, out_valid, out_idx, out_sum0, out_sum1, out_sum2, out_sum3,
               out_count, out_last, overflow
    );
endinterface

// File: rtl/kmeans_accumulator_k3_d4.sv
// Per-centroid sum/count accumulator for k-means (k=3, d=4), drained as 3 records per pass.
// Define KMEANS_ACC_SATURATE_EN to clamp sums/counts at all-ones instead of wrapping.
module kmeans_accumulator_k3_d4 #(
    parameter int input_data_width = 16,
    parameter int acc_width        = 32,
    parameter int cnt_width        = 16
) (
    input  logic clk,
    input  logic rst,
    kmeans_accumulator_k3_d4_if.slave bus
);
    typedef enum logic {ST_ACC = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [1:0]                  r_drain_idx;
    logic [1:0]                  w_drain_idx_next;
    logic                        w_in_ready;
    logic                        w_out_valid;
    logic                        w_accept;
    logic                        w_out_hs;
    logic                        w_clear;
    logic                        r_overflow;
    logic [2:0]                  w_ovf_hit;
    logic [input_data_width-1:0] w_data [4];
    logic [acc_width-1:0]        w_sum_q [3][4];
    logic [cnt_width-1:0]        w_cnt_q [3];
    logic [acc_width-1:0]        w_out_sum [4];
    logic [cnt_width-1:0]        w_out_count;

    assign w_data[0] = bus.input_data0;
    assign w_data[1] = bus.input_data1;
    assign w_data[2] = bus.input_data2;
    assign w_data[3] = bus.input_data3;

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_out_hs = w_out_valid & bus.out_ready;
    assign w_clear  = w_out_hs & (r_drain_idx == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_drain_idx <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_drain_idx <= w_drain_idx_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_drain_idx_next = r_drain_idx;
        w_in_ready       = 1'b0;
        w_out_valid      = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    w_state_next     = ST_DRAIN;
                    w_drain_idx_next = 2'd0;
                end
            end
            ST_DRAIN: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (r_drain_idx == 2'd2) begin
                        w_state_next     = ST_ACC;
                        w_drain_idx_next = 2'd0;
                    end else begin
                        w_drain_idx_next = r_drain_idx + 2'd1;
                    end
                end
            end
            default: begin
                w_state_next     = ST_ACC;
                w_drain_idx_next = 2'd0;
            end
        endcase
    end

    // One accumulator slice per centroid; index 3 matches no slice and is dropped.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cent
            logic                 w_hit;
            logic [3:0]           w_dim_carry;
            logic [cnt_width-1:0] r_cnt;
            logic [cnt_width:0]   w_cnt_ext;
            logic [cnt_width-1:0] w_cnt_new;

            assign w_hit     = w_accept && (bus.selected_centroid == 2'(gi));
            assign w_cnt_ext = {1'b0, r_cnt} + {{cnt_width{1'b0}}, 1'b1};
`ifdef KMEANS_ACC_SATURATE_EN
            assign w_cnt_new = w_cnt_ext[cnt_width] ? {cnt_width{1'b1}} : w_cnt_ext[cnt_width-1:0];
`else
            assign w_cnt_new = w_cnt_ext[cnt_width-1:0];
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_clear) begin
                    r_cnt <= '0;
                end else if (w_hit) begin
                    r_cnt <= w_cnt_new;
                end
            end

            assign w_cnt_q[gi]   = r_cnt;
            assign w_ovf_hit[gi] = w_hit & ((|w_dim_carry) | w_cnt_ext[cnt_width]);

            for (genvar gj = 0; gj < 4; gj++) begin : g_dim
                logic [acc_width-1:0] r_sum;
                logic [acc_width:0]   w_sum_ext;
                logic [acc_width-1:0] w_sum_new;

                assign w_sum_ext = {1'b0, r_sum}
                                 + {{(acc_width + 1 - input_data_width){1'b0}}, w_data[gj]};
`ifdef KMEANS_ACC_SATURATE_EN
                assign w_sum_new = w_sum_ext[acc_width] ? {acc_width{1'b1}} : w_sum_ext[acc_width-1:0];
`else
                assign w_sum_new = w_sum_ext[acc_width-1:0];
`endif
                assign w_dim_carry[gj] = w_sum_ext[acc_width];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_sum <= '0;
                    end else if (w_clear) begin
                        r_sum <= '0;
                    end else if (w_hit) begin
                        r_sum <= w_sum_new;
                    end
                end

                assign w_sum_q[gi][gj] = r_sum;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_overflow <= 1'b0;
        end else if (|w_ovf_hit) begin
            r_overflow <= 1'b1;
        end
    end

    // Record is a pure function of the drain index, so it holds while the consumer stalls.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_out_sum[j] = '0;
        end
        w_out_count = '0;
        case (r_drain_idx)
            2'd0: begin
                for (int j = 0; j < 4; j++) w_out_sum[j] = w_sum_q[0][j];
                w_out_count = w_cnt_q[0];
            end
            2'd1: begin
                for (int j = 0; j < 4; j++) w_out_sum[j] = w_sum_q[1][j];
                w_out_count = w_cnt_q[1];
            end
            2'd2: begin
                for (int j = 0; j < 4; j++) w_out_sum[j] = w_sum_q[2][j];
                w_out_count = w_cnt_q[2];
            end
            default: begin
                w_out_count = '0;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_idx   = r_drain_idx;
    assign bus.out_sum0  = w_out_sum[0];
    assign bus.out_sum1  = w_out_sum[1];
    assign bus.out_sum2  = w_out_sum[2];
    assign bus.out_sum3  = w_out_sum[3];
    assign bus.out_count = w_out_count;
    assign bus.out_last  = w_out_valid & (r_drain_idx == 2'd2);
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_kmeans_accumulator_k3_d4.sv
// Self-checking bench for kmeans_accumulator_k3_d4: directed scenarios plus randomized
// passes checked against a full-precision total model. Honors KMEANS_ACC_SATURATE_EN.
module tb_kmeans_accumulator_k3_d4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kmeans_accumulator_k3_d4_if #(.input_data_width(16), .acc_width(32), .cnt_width(16)) bus ();
    kmeans_accumulator_k3_d4_if #(.input_data_width(16), .acc_width(17), .cnt_width(16)) obus ();

    kmeans_accumulator_k3_d4 #(.input_data_width(16), .acc_width(32), .cnt_width(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    kmeans_accumulator_k3_d4 #(.input_data_width(16), .acc_width(17), .cnt_width(16)) dut_ovf (
        .clk(clk), .rst(rst), .bus(obus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: exact per-centroid totals, folded to the register width at check time.
    longint m_tot [3][4];
    longint m_cnt [3];

    logic [31:0] rec_sum [3][4];
    logic [15:0] rec_cnt [3];
    logic [1:0]  rec_idx [3];
    logic        rec_last [3];
    logic        rec_ovf [3];
    bit          rec_timeout;

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            for (int j = 0; j < 4; j++) m_tot[k][j] = 0;
        end
    endfunction

    function automatic longint exp_fold(longint total, int w);
        longint lim;
        lim = longint'(1) << w;
`ifdef KMEANS_ACC_SATURATE_EN
        return (total >= lim) ? lim - 1 : total;
`else
        return total % lim;
`endif
    endfunction

    function automatic bit model_ovf(int aw, int cw);
        bit o;
        o = 0;
        for (int k = 0; k < 3; k++) begin
            if (m_cnt[k] >= (longint'(1) << cw)) o = 1;
            for (int j = 0; j < 4; j++) if (m_tot[k][j] >= (longint'(1) << aw)) o = 1;
        end
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus.in_valid = 0; bus.in_last = 0; bus.selected_centroid = 0; bus.out_ready = 0;
        bus.input_data0 = 0; bus.input_data1 = 0; bus.input_data2 = 0; bus.input_data3 = 0;
        obus.in_valid = 0; obus.in_last = 0; obus.selected_centroid = 0; obus.out_ready = 0;
        obus.input_data0 = 0; obus.input_data1 = 0; obus.input_data2 = 0; obus.input_data3 = 0;
    endtask

    // Presents one sample for exactly one edge (block is in ACC, so it is accepted).
    task automatic send(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [15:0] d3, input logic [1:0] k, input logic last, input int gap);
        repeat (gap) step();
        bus.input_data0 = d0; bus.input_data1 = d1; bus.input_data2 = d2; bus.input_data3 = d3;
        bus.selected_centroid = k; bus.in_last = last; bus.in_valid = 1;
        step();
        bus.in_valid = 0; bus.in_last = 0;
        $display("sample k=%0d d=%0d,%0d,%0d,%0d last=%0b", k, d0, d1, d2, d3, last);
    endtask

    // Takes the three drain records, stalling out_ready randomly up to max_stall cycles.
    task automatic collect(input int max_stall);
        int waited;
        rec_timeout = 0;
        for (int r = 0; r < 3; r++) begin
            waited = 0;
            while (bus.out_valid !== 1'b1 && waited < 20) begin
                step();
                waited++;
            end
            if (bus.out_valid !== 1'b1) begin
                rec_timeout = 1;
                return;
            end
            rec_idx[r] = bus.out_idx; rec_cnt[r] = bus.out_count;
            rec_last[r] = bus.out_last; rec_ovf[r] = bus.overflow;
            rec_sum[r][0] = bus.out_sum0; rec_sum[r][1] = bus.out_sum1;
            rec_sum[r][2] = bus.out_sum2; rec_sum[r][3] = bus.out_sum3;
            repeat ($urandom_range(max_stall, 0)) step();
            bus.out_ready = 1;
            step();
            bus.out_ready = 0;
            $display("record idx=%0d count=%0d sums=%0d,%0d,%0d,%0d last=%0b ovf=%0b",
                     rec_idx[r], rec_cnt[r], rec_sum[r][0], rec_sum[r][1], rec_sum[r][2],
                     rec_sum[r][3], rec_last[r], rec_ovf[r]);
        end
    endtask

    task automatic test_reset();
        init_inputs();
        rst = 1;
        step();
        rst = 0;
        step();
        send(16'd9, 16'd9, 16'd9, 16'd9, 2'd0, 1'b0, 0);
        rst = 1;
        #2;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b want 0", bus.overflow); end
        n_cmp++; if (bus.out_idx !== 2'd0) begin n_err++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
        step();
        rst = 0;
        send(16'd0, 16'd0, 16'd0, 16'd0, 2'd3, 1'b1, 0);
        collect(0);
        n_cmp++; if (rec_timeout !== 1'b0) begin n_err++; $display("FAIL reset_drain_timeout: got 1 want 0"); end
        for (int r = 0; r < 3; r++) begin
            n_cmp++; if (rec_cnt[r] !== 16'd0) begin n_err++; $display("FAIL reset_cnt%0d: got %0d want 0", r, rec_cnt[r]); end
            for (int j = 0; j < 4; j++) begin
                n_cmp++; if (rec_sum[r][j] !== 32'd0) begin n_err++; $display("FAIL reset_sum%0d_%0d: got %0d want 0", r, j, rec_sum[r][j]); end
            end
        end
    endtask

    task automatic test_directed();
        int exp_s [3][4];
        int exp_c [3];
        exp_s = '{'{11, 22, 33, 44}, '{0, 0, 0, 0}, '{5, 5, 5, 5}};
        exp_c = '{2, 0, 1};
        send(16'd1, 16'd2, 16'd3, 16'd4, 2'd0, 1'b0, 0);
        send(16'd10, 16'd20, 16'd30, 16'd40, 2'd0, 1'b0, 0);
        send(16'd5, 16'd5, 16'd5, 16'd5, 2'd2, 1'b1, 0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL dir_latency_out_valid: got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL dir_drain_in_ready: got %0b want 0", bus.in_ready); end
        collect(0);
        n_cmp++; if (rec_timeout !== 1'b0) begin n_err++; $display("FAIL dir_timeout: got 1 want 0"); end
        for (int r = 0; r < 3; r++) begin
            n_cmp++; if (rec_idx[r] !== 2'(r)) begin n_err++; $display("FAIL dir_idx%0d: got %0d want %0d", r, rec_idx[r], r); end
            n_cmp++; if (rec_cnt[r] !== 16'(exp_c[r])) begin n_err++; $display("FAIL dir_cnt%0d: got %0d want %0d", r, rec_cnt[r], exp_c[r]); end
            n_cmp++; if (rec_last[r] !== (r == 2)) begin n_err++; $display("FAIL dir_last%0d: got %0b want %0b", r, rec_last[r], r == 2); end
            for (int j = 0; j < 4; j++) begin
                n_cmp++; if (rec_sum[r][j] !== 32'(exp_s[r][j])) begin n_err++; $display("FAIL dir_sum%0d_%0d: got %0d want %0d", r, j, rec_sum[r][j], exp_s[r][j]); end
            end
        end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL dir_in_ready_after: got %0b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL dir_out_valid_after: got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        send(16'd2, 16'd7, 16'd1, 16'd8, 2'd1, 1'b0, 0);
        send(16'd3, 16'd1, 16'd4, 16'd1, 2'd1, 1'b1, 0);
        n_cmp++; if (bus.out_idx !== 2'd0 || bus.out_count !== 16'd0) begin n_err++; $display("FAIL bp_idx0: got idx=%0d cnt=%0d want idx=0 cnt=0", bus.out_idx, bus.out_count); end
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_last = 1; bus.selected_centroid = 2'd2;
        bus.input_data0 = 16'($urandom); bus.input_data1 = 16'($urandom);
        bus.input_data2 = 16'($urandom); bus.input_data3 = 16'($urandom);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1 || bus.out_count !== 16'd2 ||
                bus.out_sum0 !== 32'd5 || bus.out_sum1 !== 32'd8 || bus.out_sum2 !== 32'd5 ||
                bus.out_sum3 !== 32'd9 || bus.out_last !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_c%0d: got v=%0b idx=%0d cnt=%0d sums=%0d,%0d,%0d,%0d last=%0b want v=1 idx=1 cnt=2 sums=5,8,5,9 last=0",
                         c, bus.out_valid, bus.out_idx, bus.out_count, bus.out_sum0, bus.out_sum1,
                         bus.out_sum2, bus.out_sum3, bus.out_last);
            end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_c%0d: got %0b want 0", c, bus.in_ready); end
            step();
        end
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        bus.in_valid = 0; bus.in_last = 0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd2 || bus.out_last !== 1'b1) begin n_err++; $display("FAIL bp_idx2: got v=%0b idx=%0d last=%0b want v=1 idx=2 last=1", bus.out_valid, bus.out_idx, bus.out_last); end
        n_cmp++; if (bus.out_count !== 16'd0) begin n_err++; $display("FAIL bp_ignored_input: got cnt2=%0d want 0", bus.out_count); end
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_after: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_invalid_centroid();
        send(16'd7, 16'd7, 16'd7, 16'd7, 2'd3, 1'b1, 0);
        collect(1);
        n_cmp++; if (rec_timeout !== 1'b0) begin n_err++; $display("FAIL k3_timeout: got 1 want 0"); end
        for (int r = 0; r < 3; r++) begin
            n_cmp++;
            if (rec_cnt[r] !== 16'd0 || rec_sum[r][0] !== 32'd0 || rec_sum[r][1] !== 32'd0 ||
                rec_sum[r][2] !== 32'd0 || rec_sum[r][3] !== 32'd0 || rec_idx[r] !== 2'(r)) begin
                n_err++;
                $display("FAIL k3_rec%0d: got idx=%0d cnt=%0d sums=%0d,%0d,%0d,%0d want idx=%0d all zero",
                         r, rec_idx[r], rec_cnt[r], rec_sum[r][0], rec_sum[r][1], rec_sum[r][2], rec_sum[r][3], r);
            end
        end
    endtask

    task automatic test_overflow();
        logic [16:0] exp_sum0;
        int waited;
`ifdef KMEANS_ACC_SATURATE_EN
        exp_sum0 = 17'h1FFFF;
`else
        exp_sum0 = 17'h0FFFD;
`endif
        for (int s = 0; s < 3; s++) begin
            obus.input_data0 = 16'hFFFF; obus.input_data1 = 0; obus.input_data2 = 0; obus.input_data3 = 0;
            obus.selected_centroid = 2'd0; obus.in_last = (s == 2); obus.in_valid = 1;
            step();
            $display("sample(ovf) k=0 d0=65535 last=%0b", s == 2);
        end
        obus.in_valid = 0; obus.in_last = 0;
        n_cmp++; if (obus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b want 1", obus.overflow); end
        n_cmp++; if (obus.out_sum0 !== exp_sum0) begin n_err++; $display("FAIL ovf_sum0: got 0x%05h want 0x%05h", obus.out_sum0, exp_sum0); end
        n_cmp++; if (obus.out_count !== 16'd3) begin n_err++; $display("FAIL ovf_count: got %0d want 3", obus.out_count); end
        waited = 0;
        while (obus.out_valid === 1'b1 && waited < 10) begin
            obus.out_ready = 1;
            step();
            waited++;
        end
        obus.out_ready = 0;
        n_cmp++; if (waited !== 3) begin n_err++; $display("FAIL ovf_drain_len: got %0d want 3", waited); end
        n_cmp++; if (obus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %0b want 0", obus.overflow); end
    endtask

    task automatic test_reset_mid_drain();
        send(16'd4, 16'd4, 16'd4, 16'd4, 2'd0, 1'b0, 0);
        send(16'd6, 16'd6, 16'd6, 16'd6, 2'd1, 1'b1, 0);
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        n_cmp++; if (bus.out_idx !== 2'd1) begin n_err++; $display("FAIL mid_idx1: got %0d want 1", bus.out_idx); end
        rst = 1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_idx !== 2'd0) begin n_err++; $display("FAIL mid_out_idx: got %0d want 0", bus.out_idx); end
        step();
        rst = 0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_record: got %0b want 0", bus.out_valid); end
        send(16'd1, 16'd1, 16'd1, 16'd1, 2'd1, 1'b1, 0);
        collect(0);
        n_cmp++; if (rec_timeout !== 1'b0) begin n_err++; $display("FAIL mid_timeout: got 1 want 0"); end
        for (int r = 0; r < 3; r++) begin
            n_cmp++;
            if (rec_cnt[r] !== ((r == 1) ? 16'd1 : 16'd0) || rec_sum[r][0] !== ((r == 1) ? 32'd1 : 32'd0) ||
                rec_sum[r][3] !== ((r == 1) ? 32'd1 : 32'd0)) begin
                n_err++;
                $display("FAIL mid_rec%0d: got cnt=%0d sum0=%0d sum3=%0d want %0d", r, rec_cnt[r], rec_sum[r][0], rec_sum[r][3], (r == 1) ? 1 : 0);
            end
        end
    endtask

    task automatic test_random();
        int n;
        logic [15:0] d [4];
        logic [1:0] k;
        for (int p = 0; p < 8; p++) begin
            model_clear();
            n = $urandom_range(20, 1);
            for (int s = 0; s < n; s++) begin
                for (int j = 0; j < 4; j++) d[j] = 16'($urandom);
                k = 2'($urandom_range(3, 0));
                send(d[0], d[1], d[2], d[3], k, s == n - 1, $urandom_range(2, 0));
                if (k != 2'd3) begin
                    m_cnt[k]++;
                    for (int j = 0; j < 4; j++) m_tot[k][j] += longint'(d[j]);
                end
            end
            collect(3);
            n_cmp++; if (rec_timeout !== 1'b0) begin n_err++; $display("FAIL rnd%0d_timeout: got 1 want 0", p); end
            for (int r = 0; r < 3; r++) begin
                n_cmp++; if (rec_idx[r] !== 2'(r)) begin n_err++; $display("FAIL rnd%0d_idx%0d: got %0d want %0d", p, r, rec_idx[r], r); end
                n_cmp++; if (rec_cnt[r] !== 16'(exp_fold(m_cnt[r], 16))) begin n_err++; $display("FAIL rnd%0d_cnt%0d: got %0d want %0d", p, r, rec_cnt[r], exp_fold(m_cnt[r], 16)); end
                n_cmp++; if (rec_ovf[r] !== model_ovf(32, 16)) begin n_err++; $display("FAIL rnd%0d_ovf%0d: got %0b want %0b", p, r, rec_ovf[r], model_ovf(32, 16)); end
                for (int j = 0; j < 4; j++) begin
                    n_cmp++; if (rec_sum[r][j] !== 32'(exp_fold(m_tot[r][j], 32))) begin n_err++; $display("FAIL rnd%0d_sum%0d_%0d: got %0d want %0d", p, r, j, rec_sum[r][j], exp_fold(m_tot[r][j], 32)); end
                end
            end
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rnd%0d_in_ready_after: got %0b want 1", p, bus.in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_invalid_centroid();
        test_overflow();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
